// File: rtl/segre_pkg.sv
// Shared Segre core types: bypass entry layout, select encoding helpers, legacy bypass enums.
// Pure declarations; no logic, no latency, no flow control.
package segre_pkg;

    localparam int BYPASS_REG_W = 8;
    localparam int BYPASS_LAT_W = 4;
    localparam int BYPASS_SEL_RF = 0;

    typedef struct packed {
        logic                    valid;
        logic                    we;
        logic [BYPASS_REG_W-1:0] wreg;
        logic [BYPASS_LAT_W-1:0] lat;
    } bypass_entry_t;

    function automatic int bypass_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int bypass_lat_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Kept for the old two-stage controller.
    typedef enum logic [1:0] {
        BYPASS_ID_RF,
        BYPASS_ID_EX,
        BYPASS_ID_MEM,
        BYPASS_ID_WB
    } bypass_id_e;

    typedef enum logic [1:0] {
        BYPASS_EX_RF,
        BYPASS_EX_MEM,
        BYPASS_EX_WB
    } bypass_ex_e;

endpackage

// File: rtl/segre_bypass_match.sv
// Per-source priority encoder over the in-flight entries; youngest matching producer wins.
// Purely combinational, zero latency; unresolved flags a match whose result is not yet forwardable.
module segre_bypass_match
    import segre_pkg::*;
#(
    parameter  int REG_SIZE = 5,
    parameter  int DEPTH    = 3,
    localparam int SEL_W    = bypass_sel_w(DEPTH)
) (
    input  bypass_entry_t [DEPTH-1:0] entries,
    input  logic [REG_SIZE-1:0]       src,
    input  logic                      src_use,
    output logic [SEL_W-1:0]          sel,
    output logic                      unresolved
);

    logic found;

    always_comb begin
        sel        = SEL_W'(BYPASS_SEL_RF);
        unresolved = 1'b0;
        found      = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && src_use && (src != '0) && entries[k].valid && entries[k].we &&
                (entries[k].wreg == BYPASS_REG_W'(src))) begin
                found = 1'b1;
                if (k >= int'(entries[k].lat)) begin
                    sel = SEL_W'(k + 1);
                end else begin
                    unresolved = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/segre_bypass_unit.sv
// Forwarding/hazard unit: tracks in-flight writes over DEPTH stages, picks bypass sources, stalls ID on unready producers.
// Select/stall are combinational from entries + ID; entries and stall counter update on the next edge; freeze holds entries.
module segre_bypass_unit
    import segre_pkg::*;
#(
    parameter  int REG_SIZE = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 3,
    parameter  int CNT_W    = 32,
    localparam int LAT_W    = bypass_lat_w(DEPTH),
    localparam int SEL_W    = bypass_sel_w(DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rsn_i,
    input  logic [NUM_SRC-1:0][REG_SIZE-1:0]  src_i,
    input  logic [NUM_SRC-1:0]                src_use_i,
    input  logic                              id_valid_i,
    input  logic                              id_we_i,
    input  logic [REG_SIZE-1:0]               dst_id_i,
    input  logic [LAT_W-1:0]                  id_lat_i,
    input  logic                              freeze_i,
    input  logic                              flush_i,
    output logic [NUM_SRC-1:0][SEL_W-1:0]     bypass_sel_o,
    output logic                              stall_o,
    output logic [CNT_W-1:0]                  stall_cnt_o
);

    bypass_entry_t [DEPTH-1:0] entries;
    bypass_entry_t             new_entry;
    logic [NUM_SRC-1:0]        unresolved;
    logic [LAT_W-1:0]          lat_clamped;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        segre_bypass_match #(
            .REG_SIZE (REG_SIZE),
            .DEPTH    (DEPTH)
        ) u_match (
            .entries    (entries),
            .src        (src_i[s]),
            .src_use    (src_use_i[s]),
            .sel        (bypass_sel_o[s]),
            .unresolved (unresolved[s])
        );
    end

    assign stall_o = id_valid_i & (|unresolved);

    // An out-of-range latency is clamped so the entry still retires as ready in the last stage.
    assign lat_clamped = (32'(id_lat_i) >= DEPTH) ? LAT_W'(DEPTH - 1) : id_lat_i;

    always_comb begin
        new_entry = '0;
        if (id_valid_i && !stall_o) begin
            new_entry.valid = 1'b1;
            new_entry.we    = id_we_i;
            new_entry.wreg  = BYPASS_REG_W'(dst_id_i);
            new_entry.lat   = BYPASS_LAT_W'(lat_clamped);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            entries <= '0;
        end else if (flush_i) begin
            entries <= '0;
        end else if (!freeze_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[0] <= new_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && !freeze_i && !flush_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    a_lat_range: assert property (@(posedge clk_i) disable iff (!rsn_i)
        id_valid_i |-> (32'(id_lat_i) < DEPTH));

endmodule

// File: tb/tb_segre_bypass_unit.sv
// Bench for segre_bypass_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_segre_bypass_unit;

    localparam int REG_SIZE = 5;
    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 3;
    localparam int CNT_W    = 4;
    localparam int LAT_W    = 2;
    localparam int SEL_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                             clk_i = 1'b0;
    logic                             rsn_i = 1'b1;
    logic [NUM_SRC-1:0][REG_SIZE-1:0] src_i;
    logic [NUM_SRC-1:0]               src_use_i;
    logic                             id_valid_i;
    logic                             id_we_i;
    logic [REG_SIZE-1:0]              dst_id_i;
    logic [LAT_W-1:0]                 id_lat_i;
    logic                             freeze_i;
    logic                             flush_i;
    logic [NUM_SRC-1:0][SEL_W-1:0]    bypass_sel_o;
    logic                             stall_o;
    logic [CNT_W-1:0]                 stall_cnt_o;

    always #5 clk_i = ~clk_i;

    segre_bypass_unit #(
        .REG_SIZE (REG_SIZE),
        .NUM_SRC  (NUM_SRC),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .src_i        (src_i),
        .src_use_i    (src_use_i),
        .id_valid_i   (id_valid_i),
        .id_we_i      (id_we_i),
        .dst_id_i     (dst_id_i),
        .id_lat_i     (id_lat_i),
        .freeze_i     (freeze_i),
        .flush_i      (flush_i),
        .bypass_sel_o (bypass_sel_o),
        .stall_o      (stall_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    // Reference model: in-flight instructions, newest first; index = pipeline stage, absent = invalid.
    typedef struct {
        bit valid;
        bit we;
        int wreg;
        int lat;
    } rent_t;

    rent_t ref_q[$];
    int    ref_cnt;
    int    exp_sel[NUM_SRC];
    bit    exp_stall;
    int    checks   = 0;
    int    failures = 0;

    function automatic void ref_eval();
        bit unres = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            exp_sel[s] = 0;
            if (src_use_i[s] && src_i[s] != 0) begin
                for (int k = 0; k < ref_q.size(); k++) begin
                    if (ref_q[k].valid && ref_q[k].we && ref_q[k].wreg == int'(src_i[s])) begin
                        if (k >= ref_q[k].lat) exp_sel[s] = k + 1;
                        else unres = 1'b1;
                        break;
                    end
                end
            end
        end
        exp_stall = id_valid_i && unres;
    endfunction

    function automatic void ref_advance();
        rent_t e;
        if (exp_stall && !freeze_i && !flush_i && ref_cnt < CNT_MAX) ref_cnt++;
        if (flush_i) begin
            ref_q.delete();
        end else if (!freeze_i) begin
            e = '{valid: 1'b0, we: 1'b0, wreg: 0, lat: 0};
            if (id_valid_i && !exp_stall) begin
                e.valid = 1'b1;
                e.we    = id_we_i;
                e.wreg  = int'(dst_id_i);
                e.lat   = (int'(id_lat_i) >= DEPTH) ? DEPTH - 1 : int'(id_lat_i);
            end
            ref_q.push_front(e);
            if (ref_q.size() > DEPTH) void'(ref_q.pop_back());
        end
    endfunction

    task automatic idle();
        id_valid_i = 1'b0; id_we_i = 1'b0; dst_id_i = '0; id_lat_i = '0;
        src_i = '0; src_use_i = '0; freeze_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic issue(input bit we, input int dst, input int lat);
        id_valid_i = 1'b1; id_we_i = we; dst_id_i = REG_SIZE'(dst); id_lat_i = LAT_W'(lat);
    endtask

    task automatic use_src(input int s, input int r);
        src_i[s] = REG_SIZE'(r); src_use_i[s] = 1'b1;
    endtask

    task automatic settle();
        #2;
        ref_eval();
    endtask

    task automatic tick();
        ref_eval();
        ref_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rsn_i = 1'b0;
        ref_q.delete();
        ref_cnt = 0;
        #2;
        rsn_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        use_src(0, 5);
        id_valid_i = 1'b1;
        #1 rsn_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_o); end
        checks++; if (bypass_sel_o !== '0) begin failures++; $display("FAIL reset_sel got=%h want=0", bypass_sel_o); end
        checks++; if (stall_cnt_o !== '0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt_o); end
        rsn_i = 1'b1;
        ref_q.delete();
        ref_cnt = 0;
        idle();
        tick();
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        issue(1, 5, 0);
        settle();
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_issue_stall got=%b want=0", stall_o); end
        tick();
        idle(); id_valid_i = 1'b1; use_src(0, 5);
        settle();
        checks++; if (bypass_sel_o[0] !== 2'd1) begin failures++; $display("FAIL alu_sel got=%0d want=1", bypass_sel_o[0]); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b want=0", stall_o); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 7, 2);
        tick();
        idle(); id_valid_i = 1'b1; use_src(1, 7);
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL load_use_stall c%0d got=%b want=1", c, stall_o); end
            checks++; if (bypass_sel_o[1] !== 2'd0) begin failures++; $display("FAIL load_use_sel_wait c%0d got=%0d want=0", c, bypass_sel_o[1]); end
            tick();
        end
        settle();
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b want=0", stall_o); end
        checks++; if (bypass_sel_o[1] !== 2'd3) begin failures++; $display("FAIL load_use_sel got=%0d want=3", bypass_sel_o[1]); end
        checks++; if (stall_cnt_o !== 4'd2) begin failures++; $display("FAIL load_use_cnt got=%0d want=2", stall_cnt_o); end
        tick();
        // The two stall edges inserted bubbles: x7 has retired, so nothing matches it now.
        idle(); id_valid_i = 1'b1; use_src(0, 7);
        settle();
        checks++; if (bypass_sel_o[0] !== 2'd0 || stall_o !== 1'b0) begin failures++; $display("FAIL load_use_retired sel=%0d stall=%b want sel=0 stall=0", bypass_sel_o[0], stall_o); end
        tick();
    endtask

    task automatic test_youngest_wins();
        do_reset();
        issue(1, 3, 0); tick();
        issue(1, 9, 0); tick();
        issue(1, 3, 0); tick();
        idle(); id_valid_i = 1'b1; use_src(0, 3); use_src(1, 9);
        settle();
        checks++; if (bypass_sel_o[0] !== 2'd1) begin failures++; $display("FAIL youngest_sel got=%0d want=1", bypass_sel_o[0]); end
        checks++; if (bypass_sel_o[1] !== 2'd2) begin failures++; $display("FAIL youngest_other_sel got=%0d want=2", bypass_sel_o[1]); end
        issue(1, 0, 0);
        tick();
        idle(); id_valid_i = 1'b1; use_src(0, 0); use_src(1, 9);
        settle();
        checks++; if (bypass_sel_o[0] !== 2'd0) begin failures++; $display("FAIL x0_sel got=%0d want=0", bypass_sel_o[0]); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b want=0", stall_o); end
        checks++; if (bypass_sel_o[1] !== 2'd3) begin failures++; $display("FAIL oldest_sel got=%0d want=3", bypass_sel_o[1]); end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        issue(1, 7, 2);
        tick();
        idle(); id_valid_i = 1'b1; use_src(0, 7);
        for (int c = 0; c < 5; c++) begin
            freeze_i = (c >= 1 && c <= 3);
            settle();
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL freeze_stall c%0d got=%b want=1", c, stall_o); end
            tick();
        end
        freeze_i = 1'b0;
        settle();
        checks++; if (stall_o !== 1'b0 || bypass_sel_o[0] !== 2'd3) begin failures++; $display("FAIL freeze_release stall=%b sel=%0d want stall=0 sel=3", stall_o, bypass_sel_o[0]); end
        checks++; if (stall_cnt_o !== 4'd2) begin failures++; $display("FAIL freeze_cnt got=%0d want=2", stall_cnt_o); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        issue(1, 7, 2);
        tick();
        idle(); id_valid_i = 1'b1; use_src(0, 7); flush_i = 1'b1;
        settle();
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL flush_comb_stall got=%b want=1", stall_o); end
        tick();
        flush_i = 1'b0;
        settle();
        checks++; if (stall_o !== 1'b0 || bypass_sel_o[0] !== 2'd0) begin failures++; $display("FAIL flush_clear stall=%b sel=%0d want 0/0", stall_o, bypass_sel_o[0]); end
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL flush_cnt got=%0d want=0", stall_cnt_o); end
        tick();
        idle(); issue(1, 4, 0); flush_i = 1'b1;
        tick();
        idle(); id_valid_i = 1'b1; use_src(0, 4);
        settle();
        checks++; if (bypass_sel_o[0] !== 2'd0) begin failures++; $display("FAIL flush_squash_sel got=%0d want=0", bypass_sel_o[0]); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(1, 7, 2);
        tick();
        idle(); id_valid_i = 1'b1; use_src(0, 7);
        settle();
        tick();
        settle();
        checks++; if (stall_o !== 1'b1 || stall_cnt_o !== 4'd1) begin failures++; $display("FAIL pre_reset stall=%b cnt=%0d want 1/1", stall_o, stall_cnt_o); end
        rsn_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL async_rst_stall got=%b want=0", stall_o); end
        checks++; if (bypass_sel_o !== '0) begin failures++; $display("FAIL async_rst_sel got=%h want=0", bypass_sel_o); end
        checks++; if (stall_cnt_o !== '0) begin failures++; $display("FAIL async_rst_cnt got=%0d want=0", stall_cnt_o); end
        ref_q.delete();
        ref_cnt = 0;
        #1 rsn_i = 1'b1;
        tick();
        idle(); issue(1, 9, 0);
        tick();
        idle(); id_valid_i = 1'b1; use_src(1, 9);
        settle();
        checks++; if (bypass_sel_o[1] !== 2'd1) begin failures++; $display("FAIL post_reset_sel got=%0d want=1", bypass_sel_o[1]); end
        tick();
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            idle(); issue(1, 7, 2);
            tick();
            idle(); id_valid_i = 1'b1; use_src(0, 7);
            tick(); tick();
            settle();
            want = (2 * (i + 1) > CNT_MAX) ? CNT_MAX : 2 * (i + 1);
            checks++; if (stall_cnt_o !== CNT_W'(want)) begin failures++; $display("FAIL sat_cnt iter%0d got=%0d want=%0d", i, stall_cnt_o, want); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            id_valid_i = ($urandom_range(0, 9) < 8);
            id_we_i    = ($urandom_range(0, 3) != 0);
            dst_id_i   = REG_SIZE'($urandom_range(0, 7));
            id_lat_i   = LAT_W'($urandom_range(0, DEPTH - 1));
            for (int s = 0; s < NUM_SRC; s++) begin
                src_i[s]     = REG_SIZE'($urandom_range(0, 7));
                src_use_i[s] = ($urandom_range(0, 3) != 0);
            end
            freeze_i = ($urandom_range(0, 9) == 0);
            flush_i  = ($urandom_range(0, 24) == 0);
            settle();
            for (int s = 0; s < NUM_SRC; s++) begin
                checks++; if (bypass_sel_o[s] !== SEL_W'(exp_sel[s])) begin failures++; $display("FAIL rand_sel cyc%0d src%0d got=%0d want=%0d", c, s, bypass_sel_o[s], exp_sel[s]); end
            end
            checks++; if (stall_o !== exp_stall) begin failures++; $display("FAIL rand_stall cyc%0d got=%b want=%b", c, stall_o, exp_stall); end
            checks++; if (stall_cnt_o !== CNT_W'(ref_cnt)) begin failures++; $display("FAIL rand_cnt cyc%0d got=%0d want=%0d", c, stall_cnt_o, ref_cnt); end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_youngest_wins();
        test_freeze();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
